// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: responder end of the CPU memory bus.
// Decodes each CPU access to work RAM ($0000-$1FFF, mirrored), the PPU
// register window ($2000-$3FFF, mirrored every 8) or cartridge PRG
// ($8000-$FFFF), and runs the OAM DMA engine started by a write to DMA_PORT.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   cpu_addr         CPU bus address
//   cpu_data_in      CPU write data
//   cpu_write_en     CPU write strobe (one cycle)
//   cpu_read_en      CPU read strobe (one cycle)
//   cpu_data_out     registered read data, valid the cycle after the strobe
//   halt, dma_busy   high while OAM DMA runs
//   ppu_reg_addr     PPU register index (combinational)
//   ppu_wr_data      PPU write data (combinational)
//   ppu_wr_en        PPU write strobe (combinational)
//   ppu_rd_en        PPU read strobe (combinational)
//   ppu_rd_data      PPU read data, combinational in ppu_reg_addr
//   cart_addr        PRG address offset from $8000 (combinational)
//   cart_rd_data     PRG data, combinational in cart_addr
//
// Build option: OPEN_BUS_EN -- unmapped reads (and reads of DMA_PORT) hold
// the previous value instead of returning 8'h00.
module cpu_bus_responder #(
  parameter int unsigned RAM_ADDR_BITS = 11,
  parameter logic [2:0]  OAM_DATA_REG  = 3'd4,
  parameter logic [15:0] DMA_PORT      = 16'h4014
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_in,
  input  logic        cpu_write_en,
  input  logic        cpu_read_en,
  output logic [7:0]  cpu_data_out,
  output logic        halt,
  output logic        dma_busy,
  output logic [2:0]  ppu_reg_addr,
  output logic [7:0]  ppu_wr_data,
  output logic        ppu_wr_en,
  output logic        ppu_rd_en,
  input  logic [7:0]  ppu_rd_data,
  output logic [14:0] cart_addr,
  input  logic [7:0]  cart_rd_data
);

  localparam int unsigned RAM_DEPTH = 2 ** RAM_ADDR_BITS;

`ifdef OPEN_BUS_EN
  localparam bit OPEN_BUS = 1'b1;
`else
  localparam bit OPEN_BUS = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_RD, S_WR} state_t;
  typedef enum logic [1:0] {RG_RAM, RG_PPU, RG_CART, RG_NONE} region_t;

  // Address map; the DMA port reads as unmapped
  function automatic region_t decode(input logic [15:0] a);
    region_t rg;
    if (a == DMA_PORT)            rg = RG_NONE;
    else if (a[15])               rg = RG_CART;
    else if (a[15:13] == 3'b000)  rg = RG_RAM;
    else if (a[15:13] == 3'b001)  rg = RG_PPU;
    else                          rg = RG_NONE;
    return rg;
  endfunction

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_page;
  logic [7:0]  r_index;
  logic [7:0]  r_buf;
  logic [7:0]  r_data_out;
  logic [7:0]  r_ram [RAM_DEPTH];

  logic        w_busy;
  logic        w_cpu_wr;
  logic        w_cpu_rd;
  logic        w_dma_rd;
  logic        w_dma_start;
  logic        w_ram_wr;
  logic [15:0] w_addr;
  region_t     w_region;
  logic [7:0]  w_rd_data;
  logic        w_rd_load;
  logic [2:0]  w_ppu_reg_addr;
  logic [7:0]  w_ppu_wr_data;
  logic        w_ppu_wr_en;
  logic        w_ppu_rd_en;
  logic [14:0] w_cart_addr;

  // Strobe qualification: CPU is locked out during DMA; write wins a collision
  assign w_busy      = (r_state != S_IDLE);
  assign w_cpu_wr    = cpu_write_en & ~w_busy & ~rst;
  assign w_cpu_rd    = cpu_read_en & ~cpu_write_en & ~w_busy & ~rst;
  assign w_dma_rd    = (r_state == S_RD) & ~rst;
  assign w_dma_start = w_cpu_wr & (cpu_addr == DMA_PORT);

  // DMA reads share the CPU read decode path
  assign w_addr   = w_dma_rd ? {r_page, r_index} : cpu_addr;
  assign w_region = decode(w_addr);
  assign w_ram_wr = w_cpu_wr & (w_region == RG_RAM);

  // Read data mux; with open bus an unmapped read leaves its target untouched
  always_comb begin
    w_rd_data = 8'h00;
    w_rd_load = 1'b1;
    case (w_region)
      RG_RAM:  w_rd_data = r_ram[w_addr[RAM_ADDR_BITS-1:0]];
      RG_PPU:  w_rd_data = ppu_rd_data;
      RG_CART: w_rd_data = cart_rd_data;
      default: w_rd_load = ~OPEN_BUS;
    endcase
  end

  // DMA state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // DMA next state and combinational PPU/cart port drive
  always_comb begin
    w_next_state   = r_state;
    w_ppu_reg_addr = 3'd0;
    w_ppu_wr_data  = 8'h00;
    w_ppu_wr_en    = 1'b0;
    w_ppu_rd_en    = 1'b0;
    w_cart_addr    = 15'd0;
    case (r_state)
      S_IDLE:  if (w_dma_start) w_next_state = S_ALIGN;
      S_ALIGN: w_next_state = S_RD;
      S_RD:    w_next_state = S_WR;
      S_WR:    w_next_state = (r_index == 8'hFF) ? S_IDLE : S_RD;
      default: w_next_state = S_IDLE;
    endcase
    if (!rst) begin
      w_cart_addr = w_addr[14:0];
      if (r_state == S_WR) begin
        w_ppu_wr_en    = 1'b1;
        w_ppu_reg_addr = OAM_DATA_REG;
        w_ppu_wr_data  = r_buf;
      end else if ((w_dma_rd || w_cpu_rd) && w_region == RG_PPU) begin
        w_ppu_rd_en    = 1'b1;
        w_ppu_reg_addr = w_addr[2:0];
      end else if (w_cpu_wr && w_region == RG_PPU) begin
        w_ppu_wr_en    = 1'b1;
        w_ppu_reg_addr = cpu_addr[2:0];
        w_ppu_wr_data  = cpu_data_in;
      end
    end
  end

  // DMA page/index/buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_page  <= 8'h00;
      r_index <= 8'h00;
      r_buf   <= 8'h00;
    end else begin
      if (w_dma_start) begin
        r_page  <= cpu_data_in;
        r_index <= 8'h00;
      end
      if (r_state == S_WR && r_index != 8'hFF) r_index <= r_index + 8'd1;
      if (w_dma_rd && w_rd_load) r_buf <= w_rd_data;
    end
  end

  // CPU read data register; holds until the next serviced read
  always_ff @(posedge clk) begin
    if (rst)                        r_data_out <= 8'h00;
    else if (w_cpu_rd && w_rd_load) r_data_out <= w_rd_data;
  end

  // Work RAM; contents survive reset
  always_ff @(posedge clk) begin
    if (w_ram_wr) r_ram[cpu_addr[RAM_ADDR_BITS-1:0]] <= cpu_data_in;
  end

  assign cpu_data_out = r_data_out;
  assign halt         = w_busy;
  assign dma_busy     = w_busy;
  assign ppu_reg_addr = w_ppu_reg_addr;
  assign ppu_wr_data  = w_ppu_wr_data;
  assign ppu_wr_en    = w_ppu_wr_en;
  assign ppu_rd_en    = w_ppu_rd_en;
  assign cart_addr    = w_cart_addr;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Scoreboard bench for cpu_bus_responder: stimulus pushes expected read data
// and expected PPU writes; a negedge monitor pops and compares.
module tb_cpu_bus_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_in;
  logic        cpu_write_en;
  logic        cpu_read_en;
  logic [7:0]  cpu_data_out;
  logic        halt;
  logic        dma_busy;
  logic [2:0]  ppu_reg_addr;
  logic [7:0]  ppu_wr_data;
  logic        ppu_wr_en;
  logic        ppu_rd_en;
  logic [7:0]  ppu_rd_data;
  logic [14:0] cart_addr;
  logic [7:0]  cart_rd_data;

  always #5 clk = ~clk;
  assign cart_rd_data = cart_addr[7:0];

  cpu_bus_responder dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
    .cpu_write_en(cpu_write_en), .cpu_read_en(cpu_read_en),
    .cpu_data_out(cpu_data_out), .halt(halt), .dma_busy(dma_busy),
    .ppu_reg_addr(ppu_reg_addr), .ppu_wr_data(ppu_wr_data),
    .ppu_wr_en(ppu_wr_en), .ppu_rd_en(ppu_rd_en), .ppu_rd_data(ppu_rd_data),
    .cart_addr(cart_addr), .cart_rd_data(cart_rd_data)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0]  mem [2048];
  logic [7:0]  last_out = 8'h00;
  bit          m_busy = 1'b0;
  logic [7:0]  rd_q [$];
  logic [10:0] ppu_q [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_rd(input logic [15:0] a, input logic [7:0] ppu,
                                          input logic [7:0] prev);
    logic [7:0] v;
    if (a == 16'h4014 || (a >= 16'h4000 && a < 16'h8000)) begin
`ifdef OPEN_BUS_EN
      v = prev;
`else
      v = 8'h00;
`endif
    end else if (a < 16'h2000) v = mem[a[10:0]];
    else if (a < 16'h4000)     v = ppu;
    else                       v = a[7:0];
    return v;
  endfunction

  // Monitor: read data one cycle after each read strobe, and every PPU write
  bit pend = 1'b0;
  always @(negedge clk) begin
    if (pend) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
      else chk("rd_data", int'(cpu_data_out), int'(rd_q.pop_front()));
    end
    pend = cpu_read_en && !rst;
    if (ppu_wr_en) begin
      if (ppu_q.size() == 0) chk("ppu_wr_unexpected", int'({ppu_reg_addr, ppu_wr_data}), 0);
      else chk("ppu_wr", int'({ppu_reg_addr, ppu_wr_data}), int'(ppu_q.pop_front()));
    end
  end

  // One bus operation: strobes high for one cycle, model updated alongside
  task automatic op(input bit rd, input bit wr, input logic [15:0] a,
                    input logic [7:0] d, input logic [7:0] pv);
    @(posedge clk); #1;
    cpu_addr = a; cpu_data_in = d; cpu_read_en = rd; cpu_write_en = wr; ppu_rd_data = pv;
    if (m_busy) begin
      if (rd) rd_q.push_back(last_out);
    end else if (wr) begin
      if (a < 16'h2000) mem[a[10:0]] = d;
      else if (a < 16'h4000) ppu_q.push_back({a[2:0], d});
      if (rd) rd_q.push_back(last_out);
    end else if (rd) begin
      last_out = model_rd(a, pv, last_out);
      rd_q.push_back(last_out);
      #1;
      if (a >= 16'h2000 && a < 16'h4000) begin
        chk("ppu_rd_en", int'(ppu_rd_en), 1);
        chk("ppu_rd_addr", int'(ppu_reg_addr), int'(a[2:0]));
      end
      if (a >= 16'h8000) chk("cart_addr", int'(cart_addr), int'(a[14:0]));
    end
    @(posedge clk); #1;
    cpu_read_en = 1'b0; cpu_write_en = 1'b0;
  endtask

  // OAM DMA from page pg; abort_at<256 resets the DUT once that index is reached
  task automatic dma(input logic [7:0] pg, input int abort_at);
    int cnt;
    bit seen;
    for (int i = 0; i < abort_at; i++)
      ppu_q.push_back({3'd4, model_rd({pg, 8'(i)}, 8'h00, 8'h00)});
    op(0, 1, 16'h4014, pg, 8'h00);
    m_busy = 1'b1;
    if (abort_at == 256) begin
      cnt = 0;
      for (int c = 0; c < 700; c++) begin
        #2;
        if (!halt) break;
        if (c == 0) chk("dma_busy", int'(dma_busy), 1);
        cnt++;
        @(posedge clk); #1;
        cpu_read_en = 1'b0; cpu_write_en = 1'b0;
        if (c == 10) begin
          cpu_addr = 16'h0005; cpu_read_en = 1'b1; rd_q.push_back(last_out);
        end else if (c == 20) begin
          cpu_addr = 16'h0300; cpu_data_in = 8'hEE; cpu_write_en = 1'b1;
        end else if (c == 30) begin
          cpu_addr = 16'h4014; cpu_data_in = 8'h03; cpu_write_en = 1'b1;
        end
      end
      cpu_read_en = 1'b0; cpu_write_en = 1'b0;
      chk("halt_len", cnt, 513);
      chk("dma_ppu_left", ppu_q.size(), 0);
      m_busy = 1'b0;
    end else begin
      seen = 1'b0;
      for (int c = 0; c < 1000; c++) begin
        #2;
        if (ppu_q.size() == 0) begin seen = 1'b1; break; end
        @(posedge clk); #1;
      end
      chk("abort_reach", int'(seen), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_halt", int'(halt), 0);
      chk("abort_busy", int'(dma_busy), 0);
      chk("abort_dout", int'(cpu_data_out), 0);
      rst = 1'b0;
      m_busy = 1'b0;
      last_out = 8'h00;
      repeat (20) @(posedge clk);
    end
  endtask

  initial begin
    logic [15:0] a;
    int          sel;
    int          kind;
    rst = 1'b1; cpu_addr = 16'h0; cpu_data_in = 8'h0;
    cpu_write_en = 1'b0; cpu_read_en = 1'b0; ppu_rd_data = 8'h0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_dout", int'(cpu_data_out), 0);
    chk("rst_halt", int'(halt), 0);
    chk("rst_busy", int'(dma_busy), 0);
    chk("rst_ppu_wr", int'(ppu_wr_en), 0);
    chk("rst_ppu_rd", int'(ppu_rd_en), 0);
    chk("rst_ppu_addr", int'(ppu_reg_addr), 0);
    chk("rst_ppu_data", int'(ppu_wr_data), 0);
    chk("rst_cart", int'(cart_addr), 0);
    @(posedge clk); #1; rst = 1'b0;

    // RAM mirror
    op(0, 1, 16'h0005, 8'hA5, 8'h00);
    op(1, 0, 16'h0805, 8'h00, 8'h00);
    op(1, 0, 16'h1805, 8'h00, 8'h00);
    // PPU window
    op(0, 1, 16'h3FFA, 8'h3C, 8'h00);
    op(1, 0, 16'h2002, 8'h00, 8'h80);
    // Cart read, dropped cart write
    op(1, 0, 16'hC012, 8'h00, 8'h00);
    op(0, 1, 16'hC012, 8'hFF, 8'h00);
    op(1, 0, 16'hC012, 8'h00, 8'h00);
    // Unmapped read after 8'h77, DMA port read, read/write collision
    op(0, 1, 16'h0040, 8'h77, 8'h00);
    op(1, 0, 16'h0040, 8'h00, 8'h00);
    op(1, 0, 16'h5000, 8'h00, 8'h00);
    op(1, 0, 16'h4014, 8'h00, 8'h00);
    op(1, 1, 16'h0010, 8'h11, 8'h00);
    op(1, 0, 16'h0010, 8'h00, 8'h00);

    // Randomised traffic over a small mirrored RAM set, PPU, cart, unmapped
    for (int i = 0; i < 16; i++) op(0, 1, 16'(i), 8'($urandom), 8'h00);
    for (int n = 0; n < 150; n++) begin
      sel  = $urandom_range(0, 3);
      kind = $urandom_range(0, 9);
      case (sel)
        0: a = 16'(($urandom_range(0, 3) << 11) | $urandom_range(0, 15));
        1: a = 16'($urandom_range(16'h2000, 16'h3FFF));
        2: a = 16'($urandom_range(16'h8000, 16'hFFFF));
        default: a = 16'($urandom_range(16'h4000, 16'h7FFF));
      endcase
      if (a == 16'h4014) a = 16'h4015;
      op(kind < 5 || kind == 9, kind >= 5, a, 8'($urandom), 8'($urandom));
    end

    // Full DMA from RAM page 2, with ignored CPU strobes in flight
    for (int i = 0; i < 256; i++) op(0, 1, {8'h02, 8'(i)}, 8'(i) ^ 8'h5A, 8'h00);
    op(0, 1, 16'h0300, 8'h33, 8'h00);
    dma(8'h02, 256);
    op(1, 0, 16'h0300, 8'h00, 8'h00);
    op(1, 0, 16'h0005, 8'h00, 8'h00);
    // Full DMA from a random cart page
    dma(8'($urandom_range(8'h80, 8'hFF)), 256);
    // Reset at index 100
    dma(8'h02, 100);
    op(1, 0, 16'h0200, 8'h00, 8'h00);

    repeat (4) @(posedge clk);
    chk("rd_q_empty", rd_q.size(), 0);
    chk("ppu_q_empty", ppu_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cpu_bus_responder.md
Name: cpu_bus_responder

Overview:
- Responder end of the CPU execute-stage memory bus: decodes every CPU access and services it from internal work RAM, the PPU register window or cartridge PRG.
- Owns the OAM DMA engine started by a write to $4014. While DMA runs it drives `halt` to freeze the CPU.
- Sits between the CPU core, the PPU register port and the cartridge.

Parameters:
- RAM_ADDR_BITS, 11, work RAM depth is 2**RAM_ADDR_BITS bytes, mirrored across $0000-$1FFF.
- OAM_DATA_REG, 3'd4, PPU register index that receives DMA bytes ($2004).
- DMA_PORT, 16'h4014, address whose write starts OAM DMA.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cpu_addr  in  16  CPU bus address
- cpu_data_in  in  8  write data from CPU
- cpu_write_en  in  1  CPU write strobe, one cycle per write
- cpu_read_en  in  1  CPU read strobe, one cycle per read
- cpu_data_out  out  8  read data to CPU
- halt  out  1  CPU stall request, high during DMA
- dma_busy  out  1  DMA engine active
- ppu_reg_addr  out  3  PPU register index
- ppu_wr_data  out  8  PPU write data
- ppu_wr_en  out  1  PPU register write strobe
- ppu_rd_en  out  1  PPU register read strobe
- ppu_rd_data  in  8  PPU read data, combinational in ppu_reg_addr while ppu_rd_en high
- cart_addr  out  15  PRG address, offset from $8000
- cart_rd_data  in  8  PRG data, combinational in cart_addr

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: cpu_data_out=0, halt=0, dma_busy=0, ppu_wr_en=0, ppu_rd_en=0, ppu_reg_addr=0, ppu_wr_data=0, cart_addr=0, DMA state IDLE, page=0, index=0. RAM contents are not cleared.
- Address decode:
  - $0000-$1FFF: RAM at addr[RAM_ADDR_BITS-1:0].
  - $2000-$3FFF: PPU register addr[2:0].
  - DMA_PORT: write-only DMA trigger.
  - $8000-$FFFF: cart, cart_addr=addr[14:0].
  - All other addresses are unmapped. Unmapped writes and writes to cart are dropped.
- Read timing:
  - cpu_data_out is registered. It loads on the edge where cpu_read_en is sampled high and is valid the cycle after, which is one cycle of latency.
  - cpu_data_out holds until the next serviced read.
  - The RAM array read is itself the registered path.
  - ppu_rd_en and ppu_reg_addr are combinational from cpu_addr/cpu_read_en in that same cycle; ppu_rd_data is sampled at that edge.
- Write timing: RAM writes land at the sampling edge. ppu_wr_en/ppu_wr_data/ppu_reg_addr are combinational pass-throughs in the strobe cycle.
- Simultaneous cpu_read_en and cpu_write_en: the write is serviced, the read is ignored and cpu_data_out holds.
- DMA state machine: IDLE -> ALIGN -> (RD -> WR) x256 -> IDLE.
  - IDLE: on a sampled write to DMA_PORT, latch page=cpu_data_in, set index=0, set halt=1 and dma_busy=1 at that edge, go to ALIGN.
  - ALIGN: one idle cycle, then go to RD.
  - RD: internal read of {page,index}, decoded exactly as a CPU read (RAM, PPU via ppu_rd_en, cart, unmapped). Result goes to an internal DMA buffer, not to cpu_data_out. Go to WR.
  - WR: ppu_wr_en=1, ppu_reg_addr=OAM_DATA_REG, ppu_wr_data=buffer.
    - If index==8'hFF: go to IDLE and clear halt/dma_busy at that edge.
    - Otherwise: index+1, go to RD.
- DMA length: halt is high for exactly 1+512=513 cycles after the trigger edge. The index is 8-bit and the page never increments, so there is no crossing into the next page.
- CPU strobes while dma_busy=1 are ignored, including a second DMA_PORT write; cpu_data_out holds.
- A reset mid-DMA aborts immediately: halt=0, state IDLE, no further PPU writes.

Optional Feature:
- Macro: OPEN_BUS_EN.
- Defined: an unmapped read, or a read of DMA_PORT, leaves cpu_data_out holding its previous value (open bus). A DMA read of an unmapped address reuses the last DMA buffer value.
- Undefined: these reads load cpu_data_out (or the DMA buffer) with 8'h00.

Test Plan:
- RAM mirror: write $0005=8'hA5, then read $0805, $1805 -> cpu_data_out=8'hA5 one cycle after each read strobe.
- PPU window: write $3FFA=8'h3C -> ppu_wr_en pulse with ppu_reg_addr=2, ppu_wr_data=8'h3C. Read $2002 with ppu_rd_data=8'h80 -> cpu_data_out=8'h80.
- Cart read: cart model returns cart_addr[7:0]; read $C012 -> cart_addr=15'h4012, cpu_data_out=8'h12. Write $C012=8'hFF -> no effect.
- DMA:
  - Stimulus: fill $0200-$02FF with index^8'h5A, then write $4014=8'h02.
  - Required: halt rises at the trigger edge and stays high 513 cycles. Exactly 256 ppu_wr_en pulses occur to reg 4, carrying the values 8'h5A..8'hA5 in index order. A CPU strobe during DMA is ignored.
- Reset mid-DMA: assert rst at DMA index 100 -> halt=0 next cycle, no more ppu_wr_en pulses. A subsequent read of $0200 returns 8'h5A.
- Unmapped/collision: read $5000 after reading 8'h77 -> 8'h00 without OPEN_BUS_EN, 8'h77 with it. Simultaneous read+write of $0010=8'h11 -> RAM updated, cpu_data_out unchanged.
